multiplier: RTL and testbench



---
 rtl/sc_pkg.sv | 10 +
 rtl/sc_lfsr.sv | 17 +
 rtl/multiplier.sv | 42 ++++
 tb/tb_multiplier.sv | 130 +++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// sc_pkg: shared widths, LFSR taps/seeds and FSM states for the stochastic multiplier.
package sc_pkg;
    localparam int SC_W = 8;
    localparam int SC_PERIOD = 255;
    localparam logic [SC_W-1:0] LFSR1_TAPS = 8'hB8;
    localparam logic [SC_W-1:0] LFSR2_TAPS = 8'hB4;
    localparam logic [SC_W-1:0] LFSR1_SEED = 8'h01;
    localparam logic [SC_W-1:0] LFSR2_SEED = 8'hFF;
    typedef enum logic [1:0] {RESET, RUN, DONE} state_t;
endpackage

// File: rtl/sc_lfsr.sv
// sc_lfsr: shift-left Fibonacci LFSR, feedback is the parity of the tapped bits entering bit0.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter logic [SC_W-1:0] TAPS = LFSR1_TAPS,
    parameter logic [SC_W-1:0] SEED = LFSR1_SEED
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic [SC_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= SEED;
        else if (en) q <= {q[SC_W-2:0], ^(q & TAPS)};
    end
endmodule

// File: rtl/multiplier.sv
// multiplier: unipolar stochastic multiply of a/255 by b/255 over one 255-cycle LFSR period.
module multiplier
    import sc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [SC_W-1:0] a,
    input  logic [SC_W-1:0] b,
    output logic [SC_W-1:0] x,
    output logic            done,
    output logic [SC_W-1:0] lfsr1_dbg,
    output logic [SC_W-1:0] lfsr2_dbg
);
    localparam logic [SC_W-1:0] LAST = SC_W'(SC_PERIOD - 1);
    state_t state, state_next;
    logic [SC_W-1:0] a_q, b_q, cnt;
    logic en, p;
    // RESET also accumulates: the first edge after release consumes the seed samples.
    assign en = state != DONE;
    assign p = (lfsr1_dbg <= a_q) && (lfsr2_dbg <= b_q);
    assign done = state == DONE;
    sc_lfsr #(.TAPS(LFSR1_TAPS), .SEED(LFSR1_SEED)) u_lfsr1 (.clk(clk), .rst(rst), .en(en), .q(lfsr1_dbg));
    sc_lfsr #(.TAPS(LFSR2_TAPS), .SEED(LFSR2_SEED)) u_lfsr2 (.clk(clk), .rst(rst), .en(en), .q(lfsr2_dbg));
    always_comb begin
        state_next = rst ? RESET
                   : state == RESET ? RUN
                   : (state == RUN && cnt == LAST) ? DONE
                   : state;
    end
    always_ff @(posedge clk) begin
        state <= state_next;
        if (rst) begin
            a_q <= a;
            b_q <= b;
            x   <= '0;
            cnt <= '0;
        end else if (en) begin
            x   <= x + SC_W'(p);
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: directed scoreboard bench with an independent bit-level LFSR golden model.
module tb_multiplier;
    logic clk = 0;
    logic rst = 1;
    logic [7:0] a = 0, b = 0;
    logic [7:0] x, lfsr1_dbg, lfsr2_dbg;
    logic done;
    int n_checks = 0;
    int n_fails = 0;
    logic [7:0] sb_q[$];
    logic [7:0] m1, m2;

    multiplier dut (.clk(clk), .rst(rst), .a(a), .b(b), .x(x), .done(done),
                    .lfsr1_dbg(lfsr1_dbg), .lfsr2_dbg(lfsr2_dbg));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] nxt1(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] nxt2(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[2]};
    endfunction

    function automatic logic [7:0] golden(input logic [7:0] ga, input logic [7:0] gb);
        logic [7:0] s1 = 8'h01, s2 = 8'hFF;
        int ones = 0;
        for (int i = 0; i < 255; i++) begin
            if (s1 <= ga && s2 <= gb) ones++;
            s1 = nxt1(s1);
            s2 = nxt2(s2);
        end
        return 8'(ones);
    endfunction

    task automatic apply_reset(input logic [7:0] na, input logic [7:0] nb);
        rst = 1;
        a = na;
        b = nb;
        step();
        check("reset_x", x, 0);
        check("reset_done", done, 0);
        check("reset_lfsr1", lfsr1_dbg, 8'h01);
        check("reset_lfsr2", lfsr2_dbg, 8'hFF);
        rst = 0;
        a = ~na;
        b = ~nb;
        m1 = 8'h01;
        m2 = 8'hFF;
    endtask

    task automatic run_to_done(input string tag);
        logic [7:0] exp, x_final;
        bit zero_seen = 0, dbg_bad = 0;
        for (int c = 1; c <= 255; c++) begin
            step();
            m1 = nxt1(m1);
            m2 = nxt2(m2);
            if (lfsr1_dbg == 0 || lfsr2_dbg == 0) zero_seen = 1;
            if (c < 255 && (lfsr1_dbg !== m1 || lfsr2_dbg !== m2)) dbg_bad = 1;
            if (c == 1 || c == 254) check({tag, "_done_early"}, done, 0);
        end
        check({tag, "_done_at_255"}, done, 1);
        check({tag, "_lfsr_track"}, dbg_bad, 0);
        check({tag, "_lfsr_nonzero"}, zero_seen, 0);
        check({tag, "_lfsr1_period"}, lfsr1_dbg, 8'h01);
        check({tag, "_lfsr2_period"}, lfsr2_dbg, 8'hFF);
        check({tag, "_sb_nonempty"}, sb_q.size() > 0, 1);
        exp = sb_q.size() > 0 ? sb_q.pop_front() : 8'h00;
        check({tag, "_x"}, x, exp);
        x_final = x;
        step();
        step();
        check({tag, "_done_sticky"}, done, 1);
        check({tag, "_x_stable"}, x, exp);
        check({tag, "_lfsr_frozen"}, lfsr1_dbg, 8'h01);
        if (tag == "golden") begin
            real err = (real'(x_final) - 170.9) / 170.9 * 100.0;
            $display("golden a=192 b=227 x=%0d relative error %0.2f%%", x_final, err);
            check("golden_tolerance", (real'(x_final) >= 162.9 && real'(x_final) <= 178.9), 1);
        end
    endtask

    initial begin
        apply_reset(8'd255, 8'd255);
        sb_q.push_back(8'd255);
        run_to_done("full");

        apply_reset(8'd0, 8'd200);
        sb_q.push_back(8'd0);
        run_to_done("zero");

        apply_reset(8'd255, 8'd128);
        sb_q.push_back(8'd128);
        run_to_done("b128");

        apply_reset(8'd64, 8'd255);
        sb_q.push_back(8'd64);
        run_to_done("a64");

        apply_reset(8'd192, 8'd227);
        sb_q.push_back(golden(8'd192, 8'd227));
        run_to_done("golden");

        apply_reset(8'd10, 8'd20);
        for (int c = 1; c <= 100; c++) step();
        check("midrun_done", done, 0);
        apply_reset(8'd255, 8'd255);
        sb_q.push_back(8'd255);
        run_to_done("restart");

        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
